// File: rtl/inst_mem_controller_if.sv
// Fetch-request and byte-wide RAM port signals shared by the instruction
// fetcher, the RAM arbiter and the instruction memory controller.
interface inst_mem_controller_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  _InstFetcher_need_inst;
  logic [31:0]           _pc;
  logic                  _mem_busy;
  logic                  _inst_ready;
  logic [31:0]           _inst;
  logic                  _mem_req;
  logic                  _mem_grant;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic [7:0]            mem_din;
  logic                  mem_wr;

  // slave: the controller; master: fetcher plus arbiter/RAM side
  modport slave (
    input  _InstFetcher_need_inst, _pc, _mem_grant, mem_din,
    output _mem_busy, _inst_ready, _inst, _mem_req, mem_a, mem_wr
  );

  modport master (
    output _InstFetcher_need_inst, _pc, _mem_grant, mem_din,
    input  _mem_busy, _inst_ready, _inst, _mem_req, mem_a, mem_wr
  );
endinterface

// File: rtl/inst_mem_controller.sv
// Instruction memory controller: reads four bytes from the byte-wide RAM port
// and returns one little-endian 32-bit instruction per fetch request.
module inst_mem_controller #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 _clear,
  inst_mem_controller_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  iss_q, iss_d;
  logic [1:0]            slot_q, slot_d;
  logic [31:0]           bytes_q, bytes_d;
  logic [31:0]           inst_q, inst_d;
  logic                  ready_q, ready_d;
  logic                  accept, issue, capture;

  assign accept  = (state_q == S_IDLE) && bus._InstFetcher_need_inst && rdy_in && !_clear;
  assign issue   = (state_q == S_READ) && bus._mem_grant && rdy_in && !_clear && (cnt_q < 3'd4);
  // RAM data answers the address issued one cycle earlier, regardless of pause or grant
  assign capture = (state_q == S_READ) && iss_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      iss_q   <= 1'b0;
      slot_q  <= 2'd0;
      mem_a_q <= '0;
      inst_q  <= 32'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
      slot_q  <= slot_d;
      mem_a_q <= mem_a_d;
      inst_q  <= inst_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk_in) begin
    addr_q  <= addr_d;
    bytes_q <= bytes_d;
  end

  always_comb begin
    state_d = state_q;
    if (_clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) state_d = S_READ;
        S_READ: if (capture && (slot_q == 2'd3)) state_d = S_DONE;
        S_DONE: if (rdy_in) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    iss_d   = 1'b0;
    slot_d  = slot_q;
    bytes_d = bytes_q;
    mem_a_d = '0;
    inst_d  = inst_q;
    ready_d = 1'b0;

    if (accept) begin
      addr_d = bus._pc[ADDR_WIDTH-1:0];
      cnt_d  = 3'd0;
    end

    if (issue) begin
      mem_a_d = addr_q + ADDR_WIDTH'(cnt_q);
      iss_d   = 1'b1;
      slot_d  = cnt_q[1:0];
      cnt_d   = cnt_q + 3'd1;
    end

    if (capture) begin
      bytes_d[{slot_q, 3'b000} +: 8] = bus.mem_din;
    end

    if ((state_q == S_DONE) && rdy_in && !_clear) begin
      inst_d  = bytes_q;
      ready_d = 1'b1;
    end

    if (_clear) begin
      cnt_d = 3'd0;
      iss_d = 1'b0;
    end
  end

  assign bus._mem_busy   = (state_q != S_IDLE);
  assign bus._mem_req    = (state_q == S_READ);
  assign bus._inst_ready = ready_q;
  assign bus._inst       = inst_q;
  assign bus.mem_a       = mem_a_q;
  assign bus.mem_wr      = 1'b0;

endmodule

// File: tb/tb_inst_mem_controller.sv
// Bench for inst_mem_controller: fixed-length stimulus windows checked cycle by
// cycle against an event-time model of the fetch protocol.
module tb_inst_mem_controller;
  localparam int MAXC = 48;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, _clear;
  logic [7:0] salt;
  int n_tests = 0;
  int n_fail  = 0;

  bit g_arr[MAXC], r_arr[MAXC], c_arr[MAXC], rst_arr[MAXC];
  bit req0;
  logic [35:0] obs_vec[MAXC], exp_vec[MAXC];
  logic [31:0] obs_inst[MAXC];
  logic [31:0] last_inst, exp_inst_end;

  inst_mem_controller_if #(.ADDR_WIDTH(32)) bus ();

  inst_mem_controller #(.ADDR_WIDTH(32)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    ._clear (_clear),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ram_rd(input logic [31:0] a, input logic [7:0] s);
    logic [31:0] h;
    logic [7:0]  d;
    case (a)
      32'h100: d = 8'h13;
      32'h101: d = 8'h05;
      32'h102: d = 8'hA0;
      32'h103: d = 8'h00;
      32'h200: d = 8'h93;
      32'h201: d = 8'h82;
      32'h202: d = 8'h40;
      32'h203: d = 8'h01;
      default: begin
        h = a * 32'h9E3779B1;
        d = h[31:24] ^ h[7:0] ^ s;
      end
    endcase
    return d;
  endfunction

  function automatic logic [31:0] ref_inst(input logic [31:0] pc, input logic [7:0] s);
    return {ram_rd(pc + 32'd3, s), ram_rd(pc + 32'd2, s), ram_rd(pc + 32'd1, s), ram_rd(pc, s)};
  endfunction

  // Combinational RAM: data follows the registered address by one cycle
  always_comb bus.mem_din = ram_rd(bus.mem_a, salt);

  task automatic set_stim(input bit g, input bit r);
    req0 = 1'b1;
    for (int k = 0; k < MAXC; k++) begin
      g_arr[k] = g; r_arr[k] = r; c_arr[k] = 1'b0; rst_arr[k] = 1'b0;
    end
  endtask

  // Entered and left at 1 time unit after a rising edge; cycle k is observed at its falling edge
  task automatic run_window(input int len, input logic [31:0] pc);
    for (int k = 0; k < len; k++) begin
      bus._InstFetcher_need_inst = (k == 0) ? req0 : 1'b0;
      bus._pc        = (k == 0) ? pc : $urandom();
      bus._mem_grant = g_arr[k];
      rdy_in         = r_arr[k];
      _clear         = c_arr[k];
      rst_in         = rst_arr[k];
      @(negedge clk_in);
      obs_vec[k]  = {bus.mem_wr, bus._mem_busy, bus._mem_req, bus._inst_ready, bus.mem_a};
      obs_inst[k] = bus._inst;
      @(posedge clk_in);
      #1;
    end
    bus._InstFetcher_need_inst = 1'b0;
    _clear = 1'b0;
    rst_in = 1'b0;
  endtask

  // Expected {wr,busy,req,ready,a} per cycle, from issue/pulse times derived from the protocol rules
  task automatic model_window(input int len, input logic [31:0] pc, input bit carry);
    int abort_c, n, p, req_end, busy_end;
    int t[4];
    bit accepted, by_rst;
    logic [31:0] ins;
    ins = ref_inst(pc, salt);
    for (int k = 0; k < MAXC; k++) exp_vec[k] = '0;
    exp_vec[0][32] = carry;
    abort_c = len;
    by_rst  = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (c_arr[k] || rst_arr[k]) begin
        abort_c = k;
        by_rst  = rst_arr[k];
        break;
      end
    end
    accepted     = req0 && r_arr[0] && (abort_c != 0);
    exp_inst_end = last_inst;
    p = -1;
    n = 0;
    if (accepted) begin
      for (int k = 1; k < abort_c && n < 4; k++) begin
        if (g_arr[k] && r_arr[k]) begin
          t[n] = k;
          n++;
        end
      end
      if (n == 4) begin
        for (int k = t[3] + 2; k < abort_c; k++) begin
          if (r_arr[k]) begin
            p = k;
            break;
          end
        end
      end
      req_end = (n == 4) ? t[3] + 1 : len - 1;
      if (req_end > abort_c) req_end = abort_c;
      if (req_end > len - 1) req_end = len - 1;
      busy_end = (p >= 0) ? p : abort_c;
      if (busy_end > len - 1) busy_end = len - 1;
      for (int k = 1; k <= busy_end; k++) exp_vec[k][34] = 1'b1;
      for (int k = 1; k <= req_end; k++) exp_vec[k][33] = 1'b1;
      for (int i = 0; i < n; i++) begin
        if (t[i] + 1 < len) exp_vec[t[i] + 1][31:0] = pc + 32'(i);
      end
      if (p >= 0) begin
        last_inst = ins;
        if (p + 1 < len) begin
          exp_vec[p + 1][32] = 1'b1;
          exp_inst_end = ins;
        end
      end
    end
    if (by_rst) begin
      last_inst = 32'h0;
      if (abort_c + 1 < len) exp_inst_end = 32'h0;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; _clear = 1'b0;
    bus._InstFetcher_need_inst = 1'b1; bus._pc = $urandom(); bus._mem_grant = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    @(negedge clk_in);
    n_tests++; if (bus._mem_busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", bus._mem_busy); end
    n_tests++; if (bus._mem_req !== 1'b0) begin n_fail++; $display("FAIL reset req got %b want 0", bus._mem_req); end
    n_tests++; if (bus._inst_ready !== 1'b0) begin n_fail++; $display("FAIL reset ready got %b want 0", bus._inst_ready); end
    n_tests++; if (bus._inst !== 32'h0) begin n_fail++; $display("FAIL reset inst got %h want 0", bus._inst); end
    n_tests++; if (bus.mem_a !== 32'h0) begin n_fail++; $display("FAIL reset mem_a got %h want 0", bus.mem_a); end
    n_tests++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset mem_wr got %b want 0", bus.mem_wr); end
    rst_in = 1'b0;
    bus._InstFetcher_need_inst = 1'b0;
    @(posedge clk_in);
    #1;
    last_inst = 32'h0;
  endtask

  task automatic test_basic();
    set_stim(1'b1, 1'b1); salt = 8'h00;
    model_window(9, 32'h100, 1'b0);
    run_window(9, 32'h100);
    for (int k = 0; k < 9; k++) begin
      n_tests++;
      if (obs_vec[k] !== exp_vec[k]) begin n_fail++; $display("FAIL basic cyc%0d {wr,busy,req,rdy,a} got %h want %h", k, obs_vec[k], exp_vec[k]); end
    end
    n_tests++; if (obs_inst[7] !== 32'h00A00513) begin n_fail++; $display("FAIL basic inst got %h want 00a00513", obs_inst[7]); end
  endtask

  task automatic test_grant_gaps();
    set_stim(1'b1, 1'b1); salt = 8'h00;
    g_arr[2] = 1'b0; g_arr[4] = 1'b0;
    model_window(11, 32'h100, 1'b0);
    run_window(11, 32'h100);
    for (int k = 0; k < 11; k++) begin
      n_tests++;
      if (obs_vec[k] !== exp_vec[k]) begin n_fail++; $display("FAIL gaps cyc%0d {wr,busy,req,rdy,a} got %h want %h", k, obs_vec[k], exp_vec[k]); end
    end
    n_tests++; if (obs_inst[9] !== 32'h00A00513) begin n_fail++; $display("FAIL gaps inst got %h want 00a00513", obs_inst[9]); end
  endtask

  task automatic test_pause();
    set_stim(1'b1, 1'b1); salt = 8'h00;
    for (int k = 3; k <= 5; k++) r_arr[k] = 1'b0;
    model_window(12, 32'h100, 1'b0);
    run_window(12, 32'h100);
    for (int k = 0; k < 12; k++) begin
      n_tests++;
      if (obs_vec[k] !== exp_vec[k]) begin n_fail++; $display("FAIL pause cyc%0d {wr,busy,req,rdy,a} got %h want %h", k, obs_vec[k], exp_vec[k]); end
    end
    n_tests++; if (obs_inst[10] !== 32'h00A00513) begin n_fail++; $display("FAIL pause inst got %h want 00a00513", obs_inst[10]); end
  endtask

  task automatic test_clear_mid();
    set_stim(1'b1, 1'b1); salt = 8'h00;
    c_arr[3] = 1'b1;
    model_window(4, 32'h100, 1'b0);
    run_window(4, 32'h100);
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (obs_vec[k] !== exp_vec[k]) begin n_fail++; $display("FAIL clrmid cyc%0d {wr,busy,req,rdy,a} got %h want %h", k, obs_vec[k], exp_vec[k]); end
    end
    set_stim(1'b1, 1'b1);
    model_window(9, 32'h200, 1'b0);
    run_window(9, 32'h200);
    for (int k = 0; k < 9; k++) begin
      n_tests++;
      if (obs_vec[k] !== exp_vec[k]) begin n_fail++; $display("FAIL clrnext cyc%0d {wr,busy,req,rdy,a} got %h want %h", k, obs_vec[k], exp_vec[k]); end
    end
    n_tests++; if (obs_inst[7] !== 32'h01408293) begin n_fail++; $display("FAIL clrnext inst got %h want 01408293", obs_inst[7]); end
  endtask

  task automatic test_clear_done();
    set_stim(1'b1, 1'b1); salt = 8'h00;
    c_arr[6] = 1'b1;
    model_window(9, 32'h100, 1'b0);
    run_window(9, 32'h100);
    for (int k = 0; k < 9; k++) begin
      n_tests++;
      if (obs_vec[k] !== exp_vec[k]) begin n_fail++; $display("FAIL clrdone cyc%0d {wr,busy,req,rdy,a} got %h want %h", k, obs_vec[k], exp_vec[k]); end
    end
    set_stim(1'b1, 1'b1);
    c_arr[0] = 1'b1;
    model_window(5, 32'h200, 1'b0);
    run_window(5, 32'h200);
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (obs_vec[k] !== exp_vec[k]) begin n_fail++; $display("FAIL clrreq cyc%0d {wr,busy,req,rdy,a} got %h want %h", k, obs_vec[k], exp_vec[k]); end
    end
    n_tests++; if (obs_inst[4] !== exp_inst_end) begin n_fail++; $display("FAIL clrreq inst got %h want %h", obs_inst[4], exp_inst_end); end
  endtask

  task automatic test_wrap();
    set_stim(1'b1, 1'b1); salt = 8'h3C;
    model_window(9, 32'hFFFFFFFE, 1'b0);
    run_window(9, 32'hFFFFFFFE);
    for (int k = 0; k < 9; k++) begin
      n_tests++;
      if (obs_vec[k] !== exp_vec[k]) begin n_fail++; $display("FAIL wrap cyc%0d {wr,busy,req,rdy,a} got %h want %h", k, obs_vec[k], exp_vec[k]); end
    end
    n_tests++; if (obs_inst[8] !== exp_inst_end) begin n_fail++; $display("FAIL wrap inst got %h want %h", obs_inst[8], exp_inst_end); end
  endtask

  task automatic test_reset_mid();
    set_stim(1'b1, 1'b1); salt = 8'h00;
    rst_arr[2] = 1'b1;
    model_window(9, 32'h100, 1'b0);
    run_window(9, 32'h100);
    for (int k = 0; k < 9; k++) begin
      n_tests++;
      if (obs_vec[k] !== exp_vec[k]) begin n_fail++; $display("FAIL rstmid cyc%0d {wr,busy,req,rdy,a} got %h want %h", k, obs_vec[k], exp_vec[k]); end
    end
    n_tests++; if (obs_inst[8] !== 32'h0) begin n_fail++; $display("FAIL rstmid inst got %h want 0", obs_inst[8]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc1, pc2;
    set_stim(1'b1, 1'b1); salt = 8'($urandom());
    pc1 = $urandom();
    model_window(7, pc1, 1'b0);
    run_window(7, pc1);
    for (int k = 0; k < 7; k++) begin
      n_tests++;
      if (obs_vec[k] !== exp_vec[k]) begin n_fail++; $display("FAIL b2b_a cyc%0d {wr,busy,req,rdy,a} got %h want %h", k, obs_vec[k], exp_vec[k]); end
    end
    pc2 = $urandom();
    model_window(9, pc2, 1'b1);
    run_window(9, pc2);
    for (int k = 0; k < 9; k++) begin
      n_tests++;
      if (obs_vec[k] !== exp_vec[k]) begin n_fail++; $display("FAIL b2b_b cyc%0d {wr,busy,req,rdy,a} got %h want %h", k, obs_vec[k], exp_vec[k]); end
    end
    n_tests++; if (obs_inst[0] !== ref_inst(pc1, salt)) begin n_fail++; $display("FAIL b2b_a inst got %h want %h", obs_inst[0], ref_inst(pc1, salt)); end
    n_tests++; if (obs_inst[8] !== exp_inst_end) begin n_fail++; $display("FAIL b2b_b inst got %h want %h", obs_inst[8], exp_inst_end); end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int it = 0; it < 30; it++) begin
      set_stim(1'b1, 1'b1);
      for (int k = 0; k < 40; k++) begin
        g_arr[k] = (k >= 25) || ($urandom_range(0, 9) < 6);
        r_arr[k] = (k >= 25) || ($urandom_range(0, 9) < 8);
      end
      if ($urandom_range(0, 3) == 0) c_arr[$urandom_range(0, 20)] = 1'b1;
      pc   = ($urandom_range(0, 1) == 1) ? $urandom() : (32'hFFFFFFFC + 32'($urandom_range(0, 3)));
      salt = 8'($urandom());
      model_window(40, pc, 1'b0);
      run_window(40, pc);
      for (int k = 0; k < 40; k++) begin
        n_tests++;
        if (obs_vec[k] !== exp_vec[k]) begin n_fail++; $display("FAIL rand%0d cyc%0d {wr,busy,req,rdy,a} got %h want %h", it, k, obs_vec[k], exp_vec[k]); end
      end
      n_tests++;
      if (obs_inst[39] !== exp_inst_end) begin n_fail++; $display("FAIL rand%0d inst got %h want %h", it, obs_inst[39], exp_inst_end); end
    end
  endtask

  initial begin
    salt = 8'h00;
    last_inst = 32'h0;
    test_reset();
    test_basic();
    test_grant_gaps();
    test_pause();
    test_clear_mid();
    test_clear_done();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
